// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serial link (transmitter and receiver).
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } tdm_state_e;

   localparam int TDM_N_CH = 4;
   localparam int TDM_W    = 8;

   // Bit offset of channel slot ch inside the packed channel-register bus.
   function automatic int unsigned slice_offset(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/tdm_shift_rx.sv
// Slot deserialiser: MSB-first shift register with a bit counter and a
// word-complete strobe. The W-th bit of a slot is taken straight from din,
// so only W-1 history bits need storage; the completed word is valid in the
// same cycle as word_done and the parent registers it on that edge.
module tdm_shift_rx
   import tdm_pkg::*;
#(
   parameter int W = TDM_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift_en,
   input  logic         restart,
   input  logic         din,
   output logic [W-1:0] word,
   output logic         word_done
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   logic [W-2:0]  hist_q, hist_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign word = {hist_q, din};

   // Shift on every accepted bit; restart makes this bit the first of a new slot.
   always_comb begin
      hist_d    = hist_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      if (shift_en) begin
         hist_d = word[W-2:0];
         if (restart) begin
            cnt_d = CW'(1);
         end else if (cnt_q == LAST_CNT) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // History and bit counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: frames on sync_in, deserialises N_CH slots of
// W bits and steers each completed slot into its own channel register.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N_CH = TDM_N_CH,
   parameter int W    = TDM_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      din,
   input  logic                      din_vld,
   input  logic                      sync_in,
   output logic [N_CH*W-1:0]         dout,
   output logic [N_CH-1:0]           dout_vld,
   output logic [$clog2(N_CH)-1:0]   ch_idx,
   output logic                      frame_done,
   output logic                      frame_err
);

   localparam int IW = $clog2(N_CH);
   localparam int OW = $clog2(N_CH * W);
   localparam logic [IW-1:0] LAST_CH = IW'(N_CH - 1);

   tdm_state_e state_q, state_d;
   logic [IW-1:0]     ch_idx_q, ch_idx_d;
   logic [N_CH*W-1:0] dout_q, dout_d;
   logic [N_CH-1:0]   dout_vld_q, dout_vld_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;

   logic          sync_hit;
   logic          shift_en;
   logic [W-1:0]  word;
   logic          word_done;
   logic [OW-1:0] slot_off;

   // A sync is only honoured on a valid bit; outside a frame nothing else is taken.
   assign sync_hit = din_vld && sync_in;
   assign shift_en = din_vld && (sync_in || (state_q == RECV));
   assign slot_off = OW'(slice_offset(32'(ch_idx_q), W));

   tdm_shift_rx #(
      .W(W)
   ) u_shift_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (shift_en),
      .restart   (sync_hit),
      .din       (din),
      .word      (word),
      .word_done (word_done)
   );

   // FSM state and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ch_idx_q     <= '0;
         dout_q       <= '0;
         dout_vld_q   <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_idx_q     <= ch_idx_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Next state: sync always restarts at channel 0, the last slot ends the frame.
   always_comb begin
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      if (sync_hit) begin
         state_d  = RECV;
         ch_idx_d = '0;
      end else if (word_done) begin
         if (ch_idx_q == LAST_CH) begin
            state_d  = IDLE;
            ch_idx_d = '0;
         end else begin
            ch_idx_d = ch_idx_q + 1'b1;
         end
      end
   end

   // Outputs: steer a completed slot into its register and raise the event pulses.
   always_comb begin
      dout_d       = dout_q;
      dout_vld_d   = '0;
      frame_done_d = 1'b0;
      frame_err_d  = sync_hit && (state_q == RECV);
      if (word_done) begin
         dout_d[slot_off +: W] = word;
         dout_vld_d            = N_CH'(1) << ch_idx_q;
         frame_done_d          = (ch_idx_q == LAST_CH);
      end
   end

   assign dout       = dout_q;
   assign dout_vld   = dout_vld_q;
   assign ch_idx     = ch_idx_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule
